// File: rtl/ex_stage.sv
// ex_stage: execute stage with the HI/LO registers and an iterative restoring divider.
// The result/forwarding path is combinational; DIV/DIVU stall the pipeline until the divider reaches DONE.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  // state | meaning
  // IDLE  | no divide in flight; DIV/DIVU latches operands here
  // BUSY  | one restoring step per cycle, count 0..DATA_W-1
  // DONE  | sign fix-up; HI/LO are written at this edge

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MFLO = 8'b00010010;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic                quo_neg_q, quo_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                div0_q, div0_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                is_div;
  logic                is_signed;
  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     diff;

  assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed = (aluop_i == OP_DIV);
  assign op1_abs   = (is_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
  assign op2_abs   = (is_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          dvd_d     = reg1_i;
          quo_neg_d = is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
          rem_neg_d = is_signed && reg1_i[DATA_W-1];
          if (reg2_i != '0) begin
            quo_d   = op1_abs;
            dvs_d   = op2_abs;
            rem_d   = '0;
            cnt_d   = '0;
            div0_d  = 1'b0;
            state_d = S_BUSY;
          end else begin
            div0_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (!is_div) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (div0_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          lo_d = quo_neg_q ? -quo_q : quo_q;
          hi_d = rem_neg_q ? -rem_q : rem_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i && !is_div;
      stallreq_o = is_div && (state_q != S_DONE);
      case (alusel_i)
        SEL_LOGIC: begin
          if (aluop_i == OP_OR) wdata_o = reg1_i | reg2_i;
        end
        SEL_MOVE: begin
          if (aluop_i == OP_MFHI)      wdata_o = hi_q;
          else if (aluop_i == OP_MFLO) wdata_o = lo_q;
        end
        default: wdata_o = '0;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
